udp_box_cmd: RTL and testbench
==============================

Name: udp_box_cmd

Overview:
- Decodes box-overlay command packets arriving on the UDP RX byte stream.
- Holds the resulting per-box coordinates and colours in registers.
- Sits directly downstream of the UDP packet receiver (rgmii_clk domain) and replaces the constant start_xs/start_ys/end_xs/end_ys/colors inputs of the frame processing stage.
- Lets the host PC move and recolour target boxes at run time.

Parameters:
- N_BOX, 1, number of box slots held; valid box ids are 0..N_BOX-1.
- H_ACT, 1280, active width; x coordinates must be <= H_ACT-1.
- V_ACT, 720, active height; y coordinates must be <= V_ACT-1.
- MAGIC, 8'hA5, required first byte of every command packet.

Ports:
- clk  input  1  rgmii_clk domain clock
- rstn  input  1  asynchronous active-low reset
- valid  input  1  RX byte strobe; high for data_len consecutive cycles per packet
- i_data  input  8  RX payload byte, sampled when valid=1
- data_len  input  16  payload length; stable while valid=1
- start_xs  output  11*N_BOX  box i start x at [11*i +: 11]
- start_ys  output  10*N_BOX  box i start y at [10*i +: 10]
- end_xs  output  11*N_BOX  box i end x
- end_ys  output  10*N_BOX  box i end y
- colors  output  24*N_BOX  box i RGB888 at [24*i +: 24]
- box_en  output  N_BOX  1 = box i drawn
- update  output  1  one-cycle pulse on each committed command
- upd_id  output  8  id of the last committed box
- cmd_err  output  1  one-cycle pulse on each rejected packet
- err_cnt  output  8  saturating count of rejected packets

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rstn).
- Reset values: all coordinate, colour and box_en outputs 0; update=0, upd_id=0, cmd_err=0, err_cnt=0.
- Packet format, 14 bytes, big-endian fields:
  - byte0: MAGIC
  - byte1: {en, id[6:0]}
  - bytes2-3: sx
  - bytes4-5: sy
  - bytes6-7: ex
  - bytes8-9: ey
  - bytes10-12: R, G, B
  - byte13: XOR of bytes 0..12
- FSM states: IDLE, BODY, CHECK, DROP.
- IDLE:
  - On valid=1 with data_len==14: capture byte0, idx=1, go to BODY.
  - On valid=1 with data_len!=14: cmd_err, go to DROP.
- BODY:
  - Each valid cycle: store byte idx, XOR-accumulate it, idx++.
  - After byte 13 is accepted: go to CHECK.
  - If valid=0 before byte 13 (truncated packet): cmd_err, go to IDLE.
- CHECK (the cycle after the last byte):
  - If valid=1 (overrun beyond 14 bytes): cmd_err, go to DROP, no commit.
  - Otherwise validate: magic match, checksum match, id<N_BOX, sx<=ex, sy<=ey, range rules (see Optional Feature).
  - Pass: commit the slot registers and box_en[id]=en, set upd_id=id, go to IDLE.
  - Fail: cmd_err, go to IDLE.
- DROP: stay until valid=0, then go to IDLE; no further cmd_err for the same packet.
- Latency: if the last byte is accepted in cycle k, the new outputs and update=1 (or cmd_err=1) appear in cycle k+2.
- Slot isolation: only slot id changes on a commit; all other slots hold.
- Coordinate width: sx/ex are truncated to 11 bits and sy/ey to 10 bits only after the range check; the check uses the full 16-bit value.
- err_cnt increments on every cmd_err and saturates at 255.
- Back-to-back packets: a new packet may start in the CHECK cycle only if it is an overrun (treated as an error); a packet starting the cycle after CHECK (back in IDLE) is accepted normally.
- Reset asserted mid-packet: immediately returns the FSM to IDLE and clears all outputs and counters.

Optional Feature:
- Macro: BOX_CLAMP_EN.
- Defined: coordinates above H_ACT-1 / V_ACT-1 are clamped to H_ACT-1 / V_ACT-1 before the sx<=ex and sy<=ey checks, and the packet is otherwise accepted.
- Undefined: any coordinate out of range rejects the packet with cmd_err, and no slot changes.

Test Plan:
- Reset release, then the packet A5 81 0064 0064 012C 012C FF 00 00 + correct XOR -> cycle k+2: update=1, upd_id=1 (N_BOX=2), box_en=2'b10, slot1 = 100,100,300,300, color FF0000; slot0 unchanged at 0.
- The same packet with the checksum byte flipped -> cmd_err pulse, err_cnt=1, no update, outputs unchanged.
- data_len=13 with 13 bytes -> one cmd_err at the first byte, DROP until valid falls; then a valid 14-byte packet commits normally.
- valid held for 16 bytes with data_len=14 -> cmd_err in the CHECK cycle, no commit, exactly one error counted.
- ex=0x0600 (1536) with a valid checksum -> without BOX_CLAMP_EN: cmd_err, no commit; with BOX_CLAMP_EN: commit with ex=1279.
- 260 bad packets in a row -> err_cnt saturates at 255; assert rstn mid-packet -> all outputs 0 and the FSM in IDLE on the next cycle.

Source files
------------

// File: rtl/udp_box_cmd_if.sv
// -----------------------------------------------------------------------------
// udp_box_cmd_if
// Byte stream from the UDP packet receiver into the box command decoder.
//   valid    : byte strobe, high for data_len consecutive cycles per packet
//   i_data   : payload byte, meaningful when valid=1
//   data_len : payload length, stable while valid=1
// Modports: master = packet receiver (drives), slave = decoder (samples).
// -----------------------------------------------------------------------------
interface udp_box_cmd_if;
   logic        valid;
   logic [7:0]  i_data;
   logic [15:0] data_len;

   modport master (output valid, output i_data, output data_len);
   modport slave  (input  valid, input  i_data, input  data_len);
endinterface

// File: rtl/udp_box_cmd.sv
// -----------------------------------------------------------------------------
// udp_box_cmd
// Decodes 14-byte box-overlay command packets from the UDP RX byte stream and
// holds per-box coordinates/colours for the frame processing stage.
//
// Packet (big-endian): A5 | {en,id[6:0]} | sx | sy | ex | ey | R G B | xor
//
// Ports:
//   clk, rstn          : rgmii_clk domain clock, async active-low reset
//   rx (slave)         : valid / i_data / data_len byte stream
//   start_xs, end_xs   : 11 bits per box, box i at [11*i +: 11]
//   start_ys, end_ys   : 10 bits per box, box i at [10*i +: 10]
//   colors             : RGB888 per box, box i at [24*i +: 24]
//   box_en             : 1 = box i drawn
//   update / upd_id    : commit pulse and id of the last committed box
//   cmd_err / err_cnt  : reject pulse and saturating reject count
//
// Build option: define BOX_CLAMP_EN to clamp out-of-range coordinates to the
// active area instead of rejecting the packet.
// -----------------------------------------------------------------------------
module udp_box_cmd #(
   parameter int         N_BOX = 1,
   parameter int         H_ACT = 1280,
   parameter int         V_ACT = 720,
   parameter logic [7:0] MAGIC = 8'hA5
) (
   input  logic                  clk,
   input  logic                  rstn,
   udp_box_cmd_if.slave          rx,
   output logic [11*N_BOX-1:0]   start_xs,
   output logic [10*N_BOX-1:0]   start_ys,
   output logic [11*N_BOX-1:0]   end_xs,
   output logic [10*N_BOX-1:0]   end_ys,
   output logic [24*N_BOX-1:0]   colors,
   output logic [N_BOX-1:0]      box_en,
   output logic                  update,
   output logic [7:0]            upd_id,
   output logic                  cmd_err,
   output logic [7:0]            err_cnt
);

   localparam logic [15:0] X_MAX   = 16'(H_ACT - 1);
   localparam logic [15:0] Y_MAX   = 16'(V_ACT - 1);
   localparam logic [15:0] PKT_LEN = 16'd14;

   typedef enum logic [1:0] {IDLE, BODY, CHECK, DROP} state_t;

   state_t      state, nxt_state;
   logic [3:0]  idx;          // index of the next byte expected in BODY
   logic [7:0]  chk;          // running XOR of all bytes, 0 when checksum is good
   logic [7:0]  pkt [0:12];   // bytes 0..12; the checksum byte lives only in chk
   logic        err, commit;

   logic [6:0]  box_id;
   logic [15:0] sx_raw, sy_raw, ex_raw, ey_raw;
   logic [15:0] sx_v, sy_v, ex_v, ey_v;
   logic        range_ok, pkt_ok;

   // ---------------- control registers ----------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         idx   <= 4'd0;
         chk   <= 8'h00;
      end else begin
         state <= nxt_state;
         if (state == IDLE && rx.valid) begin
            idx <= 4'd1;
            chk <= rx.i_data;
         end else if (state == BODY && rx.valid) begin
            idx <= idx + 4'd1;
            chk <= chk ^ rx.i_data;
         end
      end
   end

   // NOTE: the byte buffer is pure datapath, always overwritten before it is
   // used, so it carries no reset.
   always_ff @(posedge clk) begin
      if (rx.valid) begin
         if (state == IDLE)
            pkt[0] <= rx.i_data;
         else if (state == BODY && idx <= 4'd12)
            pkt[idx] <= rx.i_data;
      end
   end

   // ---------------- field decode and validation ----------------
   assign box_id = pkt[1][6:0];
   assign sx_raw = {pkt[2], pkt[3]};
   assign sy_raw = {pkt[4], pkt[5]};
   assign ex_raw = {pkt[6], pkt[7]};
   assign ey_raw = {pkt[8], pkt[9]};

   // Range handling works on the full 16-bit values; truncation to the output
   // widths happens only at commit.
   always_comb begin
      sx_v     = sx_raw;
      sy_v     = sy_raw;
      ex_v     = ex_raw;
      ey_v     = ey_raw;
      range_ok = 1'b1;
`ifdef BOX_CLAMP_EN
      if (sx_raw > X_MAX) sx_v = X_MAX;
      if (ex_raw > X_MAX) ex_v = X_MAX;
      if (sy_raw > Y_MAX) sy_v = Y_MAX;
      if (ey_raw > Y_MAX) ey_v = Y_MAX;
`else
      range_ok = (sx_raw <= X_MAX) && (ex_raw <= X_MAX) &&
                 (sy_raw <= Y_MAX) && (ey_raw <= Y_MAX);
`endif
   end

   assign pkt_ok = (pkt[0] == MAGIC) && (chk == 8'h00) &&
                   ({25'd0, box_id} < 32'(N_BOX)) &&
                   (sx_v <= ex_v) && (sy_v <= ey_v) && range_ok;

   // ---------------- next state ----------------
   // NOTE: every signal written here gets a default first, so no latches form.
   always_comb begin
      nxt_state = state;
      err       = 1'b0;
      commit    = 1'b0;
      case (state)
         IDLE:
            if (rx.valid) begin
               if (rx.data_len == PKT_LEN) begin
                  nxt_state = BODY;
               end else begin
                  err       = 1'b1;
                  nxt_state = DROP;
               end
            end
         BODY:
            if (rx.valid) begin
               if (idx == 4'd13) nxt_state = CHECK;
            end else begin
               err       = 1'b1;        // truncated packet
               nxt_state = IDLE;
            end
         CHECK:
            if (rx.valid) begin
               err       = 1'b1;        // overrun: more than 14 bytes
               nxt_state = DROP;
            end else begin
               nxt_state = IDLE;
               if (pkt_ok) commit = 1'b1;
               else        err    = 1'b1;
            end
         DROP:
            if (!rx.valid) nxt_state = IDLE;
         default:
            nxt_state = IDLE;
      endcase
   end

   // ---------------- output registers ----------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         start_xs <= '0;
         start_ys <= '0;
         end_xs   <= '0;
         end_ys   <= '0;
         colors   <= '0;
         box_en   <= '0;
         update   <= 1'b0;
         upd_id   <= 8'h00;
         cmd_err  <= 1'b0;
         err_cnt  <= 8'h00;
      end else begin
         update  <= commit;
         cmd_err <= err;
         if (err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         if (commit) begin
            upd_id <= {1'b0, box_id};
            for (int i = 0; i < N_BOX; i++) begin
               if (box_id == 7'(i)) begin
                  start_xs[11*i +: 11] <= sx_v[10:0];
                  end_xs[11*i +: 11]   <= ex_v[10:0];
                  start_ys[10*i +: 10] <= sy_v[9:0];
                  end_ys[10*i +: 10]   <= ey_v[9:0];
                  colors[24*i +: 24]   <= {pkt[10], pkt[11], pkt[12]};
                  box_en[i]            <= pkt[1][7];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_udp_box_cmd.sv
// -----------------------------------------------------------------------------
// tb_udp_box_cmd
// Scoreboard bench for udp_box_cmd with N_BOX=2. Each packet is run through a
// behavioural model before it is driven; the expected pulse (kind, cycle and
// full output snapshot) is queued and compared when the DUT pulses update or
// cmd_err. Honours BOX_CLAMP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_udp_box_cmd;

   localparam int N_BOX = 2;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   udp_box_cmd_if rx ();

   logic [11*N_BOX-1:0] start_xs, end_xs;
   logic [10*N_BOX-1:0] start_ys, end_ys;
   logic [24*N_BOX-1:0] colors;
   logic [N_BOX-1:0]    box_en;
   logic                update, cmd_err;
   logic [7:0]          upd_id, err_cnt;

   udp_box_cmd #(.N_BOX(N_BOX)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .rx       (rx),
      .start_xs (start_xs),
      .start_ys (start_ys),
      .end_xs   (end_xs),
      .end_ys   (end_ys),
      .colors   (colors),
      .box_en   (box_en),
      .update   (update),
      .upd_id   (upd_id),
      .cmd_err  (cmd_err),
      .err_cnt  (err_cnt)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   typedef struct {
      bit          is_err;
      int          cyc;
      logic [7:0]  upd_id;
      logic [21:0] sxs;
      logic [19:0] sys;
      logic [21:0] exs;
      logic [19:0] eys;
      logic [47:0] cols;
      logic [1:0]  en;
      logic [7:0]  ecnt;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   logic [7:0] pkt_q[$];

   // ---------------- reference model state ----------------
   logic [10:0] m_sx [2];
   logic [10:0] m_ex [2];
   logic [9:0]  m_sy [2];
   logic [9:0]  m_ey [2];
   logic [23:0] m_col[2];
   logic [1:0]  m_en;
   logic [7:0]  m_upd, m_ecnt;

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_sx[i] = '0; m_ex[i] = '0; m_sy[i] = '0; m_ey[i] = '0; m_col[i] = '0;
      end
      m_en = '0; m_upd = '0; m_ecnt = '0;
   endtask

   task automatic build_pkt(input bit en, input logic [6:0] id,
                            input logic [15:0] sx, input logic [15:0] sy,
                            input logic [15:0] ex, input logic [15:0] ey,
                            input logic [23:0] col);
      logic [7:0] x;
      pkt_q.delete();
      pkt_q.push_back(8'hA5);
      pkt_q.push_back({en, id});
      pkt_q.push_back(sx[15:8]); pkt_q.push_back(sx[7:0]);
      pkt_q.push_back(sy[15:8]); pkt_q.push_back(sy[7:0]);
      pkt_q.push_back(ex[15:8]); pkt_q.push_back(ex[7:0]);
      pkt_q.push_back(ey[15:8]); pkt_q.push_back(ey[7:0]);
      pkt_q.push_back(col[23:16]); pkt_q.push_back(col[15:8]); pkt_q.push_back(col[7:0]);
      x = 8'h00;
      foreach (pkt_q[i]) x ^= pkt_q[i];
      pkt_q.push_back(x);
   endtask

   task automatic fix_xor();
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < 13; i++) x ^= pkt_q[i];
      pkt_q[13] = x;
   endtask

   // Decode a complete 14-byte packet; apply it to the model when it is legal.
   task automatic decode(output bit ok);
      logic [7:0]  x, b1;
      logic [15:0] sx, sy, ex, ey;
      int          id;
      x = 8'h00;
      foreach (pkt_q[i]) x ^= pkt_q[i];
      b1 = pkt_q[1];
      id = int'(b1[6:0]);
      sx = {pkt_q[2], pkt_q[3]};
      sy = {pkt_q[4], pkt_q[5]};
      ex = {pkt_q[6], pkt_q[7]};
      ey = {pkt_q[8], pkt_q[9]};
      ok = (pkt_q[0] == 8'hA5) && (x == 8'h00) && (id < N_BOX);
`ifdef BOX_CLAMP_EN
      if (sx > 16'd1279) sx = 16'd1279;
      if (ex > 16'd1279) ex = 16'd1279;
      if (sy > 16'd719)  sy = 16'd719;
      if (ey > 16'd719)  ey = 16'd719;
`else
      if (sx > 16'd1279 || ex > 16'd1279 || sy > 16'd719 || ey > 16'd719) ok = 1'b0;
`endif
      if (sx > ex || sy > ey) ok = 1'b0;
      if (ok) begin
         m_sx[id]  = sx[10:0];
         m_ex[id]  = ex[10:0];
         m_sy[id]  = sy[9:0];
         m_ey[id]  = ey[9:0];
         m_col[id] = {pkt_q[10], pkt_q[11], pkt_q[12]};
         m_en[id]  = b1[7];
         m_upd     = 8'(id);
      end
   endtask

   // Predict the outcome of driving pkt_q with data_len=len, first byte in cycle c0.
   task automatic model_and_push(input logic [15:0] len, input int c0);
      int   n;
      bit   ok;
      exp_t e;
      n  = pkt_q.size();
      ok = 1'b0;
      if (len != 16'd14)  e.cyc = c0 + 1;
      else if (n < 14)    e.cyc = c0 + n + 1;
      else if (n > 14)    e.cyc = c0 + 15;
      else begin
         e.cyc = c0 + 15;
         decode(ok);
      end
      e.is_err = !ok;
      if (!ok && m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
      e.upd_id = m_upd;
      e.sxs    = {m_sx[1], m_sx[0]};
      e.exs    = {m_ex[1], m_ex[0]};
      e.sys    = {m_sy[1], m_sy[0]};
      e.eys    = {m_ey[1], m_ey[0]};
      e.cols   = {m_col[1], m_col[0]};
      e.en     = m_en;
      e.ecnt   = m_ecnt;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_pkt(input logic [15:0] len);
      int c0;
      c0 = cyc + 1;
      model_and_push(len, c0);
      foreach (pkt_q[i]) begin
         @(posedge clk); #1;
         rx.valid    = 1'b1;
         rx.i_data   = pkt_q[i];
         rx.data_len = len;
      end
      @(posedge clk); #1;
      rx.valid = 1'b0;
      idle(4);
      check("pending", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_sx"},  64'(start_xs), 64'd0);
      check({tag, "_sy"},  64'(start_ys), 64'd0);
      check({tag, "_ex"},  64'(end_xs),   64'd0);
      check({tag, "_ey"},  64'(end_ys),   64'd0);
      check({tag, "_col"}, 64'(colors),   64'd0);
      check({tag, "_en"},  64'(box_en),   64'd0);
      check({tag, "_upd"}, 64'(update),   64'd0);
      check({tag, "_id"},  64'(upd_id),   64'd0);
      check({tag, "_err"}, 64'(cmd_err),  64'd0);
      check({tag, "_cnt"}, 64'(err_cnt),  64'd0);
   endtask

   // ---------------- output monitor ----------------
   always @(negedge clk) begin
      if (rstn && (update || cmd_err)) begin
         if (exp_q.size() == 0) begin
            check("spurious_pulse", 64'({update, cmd_err}), 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("kind",    64'({update, cmd_err}), mon_e.is_err ? 64'd1 : 64'd2);
            check("latency", 64'(cyc),      64'(mon_e.cyc));
            check("upd_id",  64'(upd_id),   64'(mon_e.upd_id));
            check("sx",      64'(start_xs), 64'(mon_e.sxs));
            check("sy",      64'(start_ys), 64'(mon_e.sys));
            check("ex",      64'(end_xs),   64'(mon_e.exs));
            check("ey",      64'(end_ys),   64'(mon_e.eys));
            check("colors",  64'(colors),   64'(mon_e.cols));
            check("box_en",  64'(box_en),   64'(mon_e.en));
            check("err_cnt", 64'(err_cnt),  64'(mon_e.ecnt));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rx.valid    = 1'b0;
      rx.i_data   = 8'h00;
      rx.data_len = 16'd0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      rstn = 1'b1;
      idle(2);

      // Basic commit into slot 1
      build_pkt(1'b1, 7'd1, 16'd100, 16'd100, 16'd300, 16'd300, 24'hFF0000);
      send_pkt(16'd14);

      // Checksum corrupted
      build_pkt(1'b1, 7'd1, 16'd10, 16'd10, 16'd20, 16'd20, 24'h00FF00);
      pkt_q[13] = pkt_q[13] ^ 8'h01;
      send_pkt(16'd14);

      // Wrong length: 13 bytes, then a valid packet into slot 0
      build_pkt(1'b1, 7'd0, 16'd1, 16'd2, 16'd3, 16'd4, 24'h123456);
      void'(pkt_q.pop_back());
      send_pkt(16'd13);
      build_pkt(1'b1, 7'd0, 16'd5, 16'd6, 16'd700, 16'd500, 24'h0000FF);
      send_pkt(16'd14);

      // Overrun: 16 bytes with data_len=14
      build_pkt(1'b1, 7'd1, 16'd0, 16'd0, 16'd1, 16'd1, 24'hABCDEF);
      pkt_q.push_back(8'h11);
      pkt_q.push_back(8'h22);
      send_pkt(16'd14);

      // ex=1536: reject by default, clamp to 1279 with BOX_CLAMP_EN
      build_pkt(1'b1, 7'd0, 16'd100, 16'd50, 16'h0600, 16'd60, 24'h808080);
      send_pkt(16'd14);

      // Boundary coordinates exactly at the active edge, box disabled
      build_pkt(1'b0, 7'd1, 16'd1279, 16'd719, 16'd1279, 16'd719, 24'hC0FFEE);
      send_pkt(16'd14);

      // Bad id, sx>ex, sy>ey, bad magic, truncated
      build_pkt(1'b1, 7'd5, 16'd1, 16'd1, 16'd2, 16'd2, 24'h010203);
      send_pkt(16'd14);
      build_pkt(1'b1, 7'd0, 16'd200, 16'd1, 16'd199, 16'd2, 24'h010203);
      send_pkt(16'd14);
      build_pkt(1'b1, 7'd0, 16'd1, 16'd300, 16'd2, 16'd299, 24'h010203);
      send_pkt(16'd14);
      build_pkt(1'b1, 7'd0, 16'd1, 16'd1, 16'd2, 16'd2, 24'h010203);
      pkt_q[0] = 8'h5A;
      fix_xor();
      send_pkt(16'd14);
      build_pkt(1'b1, 7'd0, 16'd1, 16'd1, 16'd2, 16'd2, 24'h010203);
      while (pkt_q.size() > 10) void'(pkt_q.pop_back());
      send_pkt(16'd14);

      // Recovery after errors: slot 1 again
      build_pkt(1'b1, 7'd1, 16'd40, 16'd41, 16'd42, 16'd43, 24'h445566);
      send_pkt(16'd14);

      // 260 short bad packets: err_cnt saturates
      for (int i = 0; i < 260; i++) begin
         pkt_q.delete();
         pkt_q.push_back(8'(i));
         pkt_q.push_back(8'hA5);
         send_pkt(16'd2);
      end
      check("err_cnt_sat", 64'(err_cnt), 64'd255);

      // Reset asserted mid-packet
      build_pkt(1'b1, 7'd0, 16'd9, 16'd9, 16'd10, 16'd10, 24'h999999);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         rx.valid    = 1'b1;
         rx.i_data   = pkt_q[i];
         rx.data_len = 16'd14;
      end
      rstn = 1'b0;
      @(negedge clk);
      check_all_zero("midrst");
      rx.valid = 1'b0;
      model_reset();
      @(posedge clk); #1;
      rstn = 1'b1;
      idle(1);

      // FSM must be back in IDLE: a fresh packet commits normally
      build_pkt(1'b1, 7'd0, 16'd9, 16'd9, 16'd10, 16'd10, 24'h999999);
      send_pkt(16'd14);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
